// File: rtl/prog_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM states,
// checksum width and the bytes-per-word derivation.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_CSUM  = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } state_t;

    localparam int CSUM_W = 8;

    function automatic int bpw(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/prog_loader_word_assembler.sv
// Purpose: shift little-endian bytes into a memory word, pulse when the word is complete.
// Latency: word_vld_o one cycle after the word's last byte is accepted.
// Backpressure: none; the caller only strobes byte_vld_i on accepted bytes.
module prog_loader_word_assembler
    import prog_loader_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              clr_i,
    input  logic              byte_vld_i,
    input  logic [7:0]        byte_dat_i,
    output logic              last_o,
    output logic              word_vld_o,
    output logic [DATA_W-1:0] word_o
);

    localparam int BPW   = bpw(DATA_W);
    localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] sh_q;
    logic [DATA_W-1:0] sh_nxt;

    assign last_o = (cnt_q == CNT_W'(BPW - 1));

    // New bytes enter at the top so the first byte ends up in the LSBs.
    if (BPW > 1) begin : g_shift
        assign sh_nxt = {byte_dat_i, sh_q[DATA_W-1:8]};
    end else begin : g_single
        assign sh_nxt = byte_dat_i;
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            cnt_q      <= '0;
            sh_q       <= '0;
            word_o     <= '0;
            word_vld_o <= 1'b0;
        end else begin
            word_vld_o <= 1'b0;
            if (clr_i) begin
                cnt_q <= '0;
                sh_q  <= '0;
            end else if (byte_vld_i) begin
                sh_q <= sh_nxt;
                if (last_o) begin
                    cnt_q      <= '0;
                    word_o     <= sh_nxt;
                    word_vld_o <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Purpose: framed byte-stream loader (length, words, checksum) into instruction memory; holds the core until a clean load.
// Latency: start->rx_ready 1 cycle; last data byte->mem_wen 1 cycle; checksum byte->done/core release 1 cycle.
// Backpressure: rx_ready_o is a pure state decode; up to 1 byte/cycle, gaps on rx_valid_i simply stall the frame.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W    = 11,
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 16,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    output logic              mem_wen_o,
    output logic              core_reset_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [LEN_W-1:0]  words_o
);

    localparam int BPW    = bpw(DATA_W);
    localparam int LB     = LEN_W / 8;
    localparam int LCNT_W = (LB > 1) ? $clog2(LB) : 1;
    localparam int PW     = LEN_W + ADDR_W + 2;
    localparam int LW1    = LEN_W + 1;
    localparam logic [PW-1:0] CAP_BYTES = (PW'(1) << ADDR_W) - PW'(BASE_ADDR);

    state_t              state_q, state_nxt;
    logic [LCNT_W-1:0]   len_cnt_q;
    logic [LEN_W-1:0]    n_q, n_full;
    logic [CSUM_W-1:0]   csum_q, csum_nxt;
    logic [LEN_W-1:0]    words_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                byte_acc, sess_go, len_last, oversize, last_word;
    logic                asm_last, word_vld;
    logic [PW-1:0]       need_bytes;

    assign byte_acc   = rx_valid_i && rx_ready_o;
    assign sess_go    = start_i && (state_q inside {ST_IDLE, ST_DONE, ST_ERROR});
    assign len_last   = (len_cnt_q == LCNT_W'(LB - 1));
    assign csum_nxt   = csum_q + rx_data_i;
    assign need_bytes = PW'(n_full) * PW'(BPW);
    assign oversize   = need_bytes > CAP_BYTES;
    // words_q already counts every word whose last byte has been accepted.
    assign last_word  = (LW1'(words_q) + LW1'(1)) == LW1'(n_q);

    if (LB > 1) begin : g_len_shift
        assign n_full = {rx_data_i, n_q[LEN_W-1:8]};
    end else begin : g_len_byte
        assign n_full = rx_data_i;
    end

    prog_loader_word_assembler #(
        .DATA_W (DATA_W)
    ) u_asm (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .clr_i      (sess_go),
        .byte_vld_i (byte_acc && (state_q == ST_DATA)),
        .byte_dat_i (rx_data_i),
        .last_o     (asm_last),
        .word_vld_o (word_vld),
        .word_o     (mem_data_o)
    );

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) state_q <= ST_IDLE;
        else          state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: if (start_i) state_nxt = ST_LEN;
            ST_LEN: if (byte_acc && len_last) begin
                if (oversize)          state_nxt = ST_ERROR;
                else if (n_full == '0) state_nxt = ST_CSUM;
                else                   state_nxt = ST_DATA;
            end
            ST_DATA: if (byte_acc && asm_last && last_word) state_nxt = ST_CSUM;
            ST_CSUM: if (byte_acc) state_nxt = (csum_nxt == '0) ? ST_DONE : ST_ERROR;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        rx_ready_o   = 1'b0;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        err_o        = 1'b0;
        core_reset_o = 1'b0;
        case (state_q)
            ST_LEN, ST_DATA, ST_CSUM: begin
                rx_ready_o = 1'b1;
                busy_o     = 1'b1;
            end
            ST_DONE: begin
                done_o       = 1'b1;
                core_reset_o = 1'b1;
            end
            ST_ERROR: err_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            len_cnt_q <= '0;
            n_q       <= '0;
            csum_q    <= '0;
            words_q   <= '0;
            addr_q    <= ADDR_W'(BASE_ADDR);
        end else if (sess_go) begin
            len_cnt_q <= '0;
            n_q       <= '0;
            csum_q    <= '0;
            words_q   <= '0;
            addr_q    <= ADDR_W'(BASE_ADDR);
        end else begin
            if (byte_acc) csum_q <= csum_nxt;
            if (byte_acc && state_q == ST_LEN) begin
                n_q       <= n_full;
                len_cnt_q <= len_last ? '0 : len_cnt_q + LCNT_W'(1);
            end
            // Counted on the same edge that raises mem_wen_o.
            if (byte_acc && state_q == ST_DATA && asm_last) words_q <= words_q + LEN_W'(1);
            if (word_vld) addr_q <= addr_q + ADDR_W'(BPW);
        end
    end

    assign mem_wen_o  = word_vld;
    assign mem_addr_o = addr_q;
    assign words_o    = words_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: fixed frame table, hand-built corner sequences and random frames vs a stream-level model.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        reset_i, start_i, rx_valid_i;
    logic [7:0]  rx_data_i;
    logic        rx_ready_o, mem_wen_o, core_reset_o, busy_o, done_o, err_o;
    logic [10:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [15:0] words_o;

    prog_loader dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .start_i      (start_i),
        .rx_data_i    (rx_data_i),
        .rx_valid_i   (rx_valid_i),
        .rx_ready_o   (rx_ready_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_wen_o    (mem_wen_o),
        .core_reset_o (core_reset_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .words_o      (words_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]  tx_q[$];
    logic [31:0] wr_a[$], wr_d[$];
    logic [31:0] exp_a[$], exp_d[$];
    bit          exp_done, exp_err;
    int          exp_words;

    typedef struct {
        logic [127:0] bytes;   // byte k of the frame at [8k +: 8]
        int           n;
        bit           done;
        bit           err;
        int           words;
        int           nwr;
        logic [31:0]  d0;
        logic [31:0]  d1;
    } vec_t;

    vec_t vt[6];

    always @(negedge clk) begin
        if (mem_wen_o === 1'b1) begin
            wr_a.push_back(32'(mem_addr_o));
            wr_d.push_back(mem_data_o);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_ready", rx_ready_o, 0);
        chk("rst_wen", mem_wen_o, 0);
        chk("rst_addr", mem_addr_o, 0);
        chk("rst_data", mem_data_o, 0);
        chk("rst_core", core_reset_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_words", words_o, 0);
    endtask

    task automatic do_start();
        wr_a.delete();
        wr_d.delete();
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        chk("start_busy", busy_o, 1);
        chk("start_ready", rx_ready_o, 1);
        chk("start_core", core_reset_o, 0);
        chk("start_done", done_o, 0);
        chk("start_err", err_o, 0);
        chk("start_words", words_o, 0);
    endtask

    // Drives tx_q with optional idle gaps; pulse_at >= 0 raises start_i while that byte is offered.
    task automatic send(input int gap_pct, input int pulse_at);
        int idx = 0;
        int cyc = 0;
        int budget = tx_q.size() * 20 + 100;
        bit pulsed = 1'b0;
        while (idx < tx_q.size() && cyc < budget) begin
            @(negedge clk);
            cyc++;
            start_i = 1'b0;
            if (pulse_at >= 0 && idx == pulse_at && !pulsed) begin
                start_i = 1'b1;
                pulsed  = 1'b1;
            end
            if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                rx_valid_i = 1'b0;
                rx_data_i  = 8'($urandom);
            end else begin
                rx_valid_i = 1'b1;
                rx_data_i  = tx_q[idx];
                if (rx_ready_o) idx++;
            end
        end
        @(negedge clk);
        rx_valid_i = 1'b0;
        start_i    = 1'b0;
        chk("send_all", idx, tx_q.size());
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy_o && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("idle_timeout", busy_o, 0);
    endtask

    task automatic check_end();
        chk("end_done", done_o, exp_done);
        chk("end_err", err_o, exp_err);
        chk("end_core", core_reset_o, exp_done);
        chk("end_words", words_o, exp_words);
        chk("end_ready", rx_ready_o, 0);
        chk("nwrites", wr_a.size(), exp_a.size());
        for (int k = 0; k < wr_a.size() && k < exp_a.size(); k++) begin
            chk("wr_addr", wr_a[k], exp_a[k]);
            chk("wr_data", wr_d[k], exp_d[k]);
        end
    endtask

    // Frame semantics: 16-bit LE count, count LE words, one byte making the sum 0 mod 256.
    task automatic model();
        int n, sum;
        exp_a.delete();
        exp_d.delete();
        n = int'(tx_q[0]) + 256 * int'(tx_q[1]);
        if (n * 4 > 2048) begin
            exp_err = 1; exp_done = 0; exp_words = 0;
        end else begin
            for (int w = 0; w < n; w++) begin
                exp_a.push_back(32'(4 * w));
                exp_d.push_back({tx_q[2+4*w+3], tx_q[2+4*w+2], tx_q[2+4*w+1], tx_q[2+4*w]});
            end
            sum = 0;
            foreach (tx_q[k]) sum += int'(tx_q[k]);
            exp_done  = (sum % 256) == 0;
            exp_err   = !exp_done;
            exp_words = n;
        end
    endtask

    task automatic load_vec(input int i);
        logic [127:0] b = vt[i].bytes;
        tx_q.delete();
        for (int k = 0; k < vt[i].n; k++) tx_q.push_back(b[8*k +: 8]);
        exp_a.delete();
        exp_d.delete();
        if (vt[i].nwr > 0) begin exp_a.push_back(0); exp_d.push_back(vt[i].d0); end
        if (vt[i].nwr > 1) begin exp_a.push_back(4); exp_d.push_back(vt[i].d1); end
        exp_done  = vt[i].done;
        exp_err   = vt[i].err;
        exp_words = vt[i].words;
    endtask

    task automatic rand_frame(input int n, input bit corrupt);
        int sum = 0;
        logic [7:0] c;
        tx_q.delete();
        tx_q.push_back(8'(n));
        tx_q.push_back(8'(n >> 8));
        if (n * 4 <= 2048) begin
            for (int k = 0; k < 4 * n; k++) tx_q.push_back(8'($urandom));
            foreach (tx_q[k]) sum += int'(tx_q[k]);
            c = 8'((256 - (sum % 256)) % 256);
            if (corrupt) c = c ^ 8'($urandom_range(1, 255));
            tx_q.push_back(c);
        end
    endtask

    initial begin
        vt[0] = '{bytes: 128'h8E_00_01_04_33_24_00_01_13_00_02, n: 11, done: 1, err: 0, words: 2, nwr: 2,
                  d0: 32'h24000113, d1: 32'h00010433};
        vt[1] = '{bytes: 128'h8F_00_01_04_33_24_00_01_13_00_02, n: 11, done: 0, err: 1, words: 2, nwr: 2,
                  d0: 32'h24000113, d1: 32'h00010433};
        vt[2] = '{bytes: 128'h00_00_00, n: 3, done: 1, err: 0, words: 0, nwr: 0, d0: 0, d1: 0};
        vt[3] = '{bytes: 128'h02_01, n: 2, done: 0, err: 1, words: 0, nwr: 0, d0: 0, d1: 0};
        vt[4] = '{bytes: 128'hAA_02_40_00_13_00_01, n: 7, done: 1, err: 0, words: 1, nwr: 1,
                  d0: 32'h02400013, d1: 0};
        vt[5] = '{bytes: 128'h96_02_40_00_13_00_01, n: 7, done: 0, err: 1, words: 1, nwr: 1,
                  d0: 32'h02400013, d1: 0};

        reset_i = 1'b0; start_i = 1'b0; rx_valid_i = 1'b1; rx_data_i = 8'h55;
        repeat (3) @(negedge clk);
        chk_reset_vals();
        rx_valid_i = 1'b0;
        reset_i = 1'b1;
        @(negedge clk);
        chk("idle_ignores_valid", rx_ready_o, 0);

        for (int i = 0; i < 6; i++) begin
            load_vec(i);
            do_start();
            send(0, -1);
            wait_idle();
            check_end();
        end

        // Gapped nominal frame with a start pulse mid-stream.
        load_vec(0);
        do_start();
        send(50, 4);
        wait_idle();
        check_end();

        // Reset mid-load after five accepted bytes, then a clean reload.
        load_vec(0);
        tx_q = tx_q[0:4];
        do_start();
        send(0, -1);
        chk("midload_busy", busy_o, 1);
        reset_i = 1'b0;
        #1;
        chk_reset_vals();
        @(negedge clk);
        reset_i = 1'b1;
        load_vec(0);
        do_start();
        send(0, -1);
        wait_idle();
        check_end();

        // Restart from DONE with one word; core reset must fall on the start edge.
        chk("pre_restart_core", core_reset_o, 1);
        load_vec(4);
        do_start();
        send(0, -1);
        wait_idle();
        check_end();

        // Exactly full memory: 512 words is legal.
        rand_frame(512, 0);
        model();
        do_start();
        send(0, -1);
        wait_idle();
        check_end();

        for (int it = 0; it < 24; it++) begin
            int n = ($urandom_range(0, 7) == 0) ? 513 + int'($urandom_range(0, 3000)) : int'($urandom_range(0, 6));
            rand_frame(n, $urandom_range(0, 3) == 0);
            model();
            do_start();
            send(50, ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, tx_q.size() - 1)) : -1);
            wait_idle();
            check_end();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
